fp_normalizer: RTL and testbench

Post-add normalization stage of the floating-point unit. Consumes the raw 24-bit mantissa sum, adder carry-out, sign and pre-aligned exponent from the mantissa adder stage, and produces a normalized single-precision sign/exponent/fraction. It right-shifts once on carry, or left-shifts iteratively, one bit per cycle, until the hidden bit is set. Zero, exponent overflow and underflow (flush-to-zero) are handled here. Valid/ready handshakes are used on both sides.

---
 rtl/fp_normalizer.sv | 139 +++++++++++++
 tb/tb_fp_normalizer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalizer.sv
// Post-add normalization stage: right-shift on carry, iterative left-shift until the hidden bit
// is set, with zero, overflow-to-infinity and flush-to-zero underflow handling.
module fp_normalizer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [23:0] in_mant,
    input  logic        in_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [7:0]  out_exp,
    output logic [22:0] out_frac,
    output logic [4:0]  out_shift,
    output logic        out_zero,
    output logic        out_overflow,
    output logic        out_underflow
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, nxt_state;
    logic        sign, nxt_sign;
    logic [7:0]  exp, nxt_exp;
    logic [23:0] mant, nxt_mant;
    logic [4:0]  shift_cnt, nxt_shift_cnt;
    logic        zero, nxt_zero;
    logic        ovf, nxt_ovf;
    logic        unf, nxt_unf;

    assign in_ready = (state == IDLE);

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        nxt_state     = state;
        nxt_sign      = sign;
        nxt_exp       = exp;
        nxt_mant      = mant;
        nxt_shift_cnt = shift_cnt;
        nxt_zero      = zero;
        nxt_ovf       = ovf;
        nxt_unf       = unf;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    nxt_sign      = in_sign;
                    nxt_shift_cnt = '0;
                    nxt_zero      = 1'b0;
                    nxt_ovf       = 1'b0;
                    nxt_unf       = 1'b0;
                    nxt_exp       = in_exp;
                    nxt_mant      = in_mant;
                    nxt_state     = DONE;
                    if (in_cout) begin
                        if (in_exp >= 8'd254) begin
                            nxt_exp  = 8'd255;
                            nxt_mant = '0;
                            nxt_ovf  = 1'b1;
                        end else begin
                            nxt_exp  = in_exp + 8'd1;
                            nxt_mant = {1'b1, in_mant[23:1]};
                        end
                    end else if (in_mant == '0) begin
                        nxt_exp  = '0;
                        nxt_zero = 1'b1;
                    end else if (!in_mant[23]) begin
                        nxt_state = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (exp <= 8'd1) begin
                    // Exponent cannot absorb another shift: flush to zero.
                    nxt_exp   = '0;
                    nxt_mant  = '0;
                    nxt_unf   = 1'b1;
                    nxt_zero  = 1'b1;
                    nxt_state = DONE;
                end else begin
                    nxt_mant      = {mant[22:0], 1'b0};
                    nxt_exp       = exp - 8'd1;
                    nxt_shift_cnt = shift_cnt + 5'd1;
                    if (mant[22]) nxt_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the whole datapath is reset
    // because it is a handful of flops, not a memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sign          <= 1'b0;
            exp           <= '0;
            mant          <= '0;
            shift_cnt     <= '0;
            zero          <= 1'b0;
            ovf           <= 1'b0;
            unf           <= 1'b0;
            out_valid     <= 1'b0;
            out_sign      <= 1'b0;
            out_exp       <= '0;
            out_frac      <= '0;
            out_shift     <= '0;
            out_zero      <= 1'b0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
        end else begin
            state     <= nxt_state;
            sign      <= nxt_sign;
            exp       <= nxt_exp;
            mant      <= nxt_mant;
            shift_cnt <= nxt_shift_cnt;
            zero      <= nxt_zero;
            ovf       <= nxt_ovf;
            unf       <= nxt_unf;
            out_valid <= (nxt_state == DONE);
            // Output fields are captured only on entry to DONE and otherwise hold.
            if (state != DONE && nxt_state == DONE) begin
                out_sign      <= nxt_sign;
                out_exp       <= nxt_exp;
                out_frac      <= nxt_mant[22:0];
                out_shift     <= nxt_shift_cnt;
                out_zero      <= nxt_zero;
                out_overflow  <= nxt_ovf;
                out_underflow <= nxt_unf;
            end
        end
    end

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed self-checking bench for fp_normalizer: hand-computed vectors checked with
// immediate assertions, including latency, backpressure and mid-operation reset.
module tb_fp_normalizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [23:0] in_mant = '0;
    logic        in_cout = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_frac;
    logic [4:0]  out_shift;
    logic        out_zero;
    logic        out_overflow;
    logic        out_underflow;

    int n_cmp = 0;
    int n_err = 0;
    int lat;

    fp_normalizer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign), .in_exp(in_exp),
        .in_mant(in_mant), .in_cout(in_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_exp(out_exp),
        .out_frac(out_frac), .out_shift(out_shift), .out_zero(out_zero),
        .out_overflow(out_overflow), .out_underflow(out_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Present one operand set, accept it, and count edges until out_valid (accept edge = 1).
    task automatic run_op(input logic s, input logic [7:0] e, input logic [23:0] m, input logic c);
        @(negedge clk);
        in_sign = s; in_exp = e; in_mant = m; in_cout = c; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic check_flags(input string tag, input logic z, input logic o, input logic u);
        check({tag, "_zero"}, 32'(out_zero), 32'(z));
        check({tag, "_ovf"}, 32'(out_overflow), 32'(o));
        check({tag, "_unf"}, 32'(out_underflow), 32'(u));
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_exp", 32'(out_exp), 32'd0);
        check("rst_frac", 32'(out_frac), 32'd0);
        check("rst_shift", 32'(out_shift), 32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        // Carry: 0x800000 with carry -> 0xC00000, exponent +1
        run_op(1'b0, 8'd127, 24'h800000, 1'b1);
        check("carry_lat", 32'(lat), 32'd1);
        check("carry_exp", 32'(out_exp), 32'd128);
        check("carry_frac", 32'(out_frac), 32'h400000);
        check("carry_shift", 32'(out_shift), 32'd0);
        check("carry_sign", 32'(out_sign), 32'd0);
        check_flags("carry", 1'b0, 1'b0, 1'b0);
        release_out("carry");

        // Deep shift: 23 left shifts
        run_op(1'b0, 8'd127, 24'h000001, 1'b0);
        check("deep_lat", 32'(lat), 32'd24);
        check("deep_exp", 32'(out_exp), 32'd104);
        check("deep_frac", 32'(out_frac), 32'h0);
        check("deep_shift", 32'(out_shift), 32'd23);
        check_flags("deep", 1'b0, 1'b0, 1'b0);
        release_out("deep");

        // Exact zero keeps its sign
        run_op(1'b1, 8'd50, 24'h000000, 1'b0);
        check("zero_lat", 32'(lat), 32'd1);
        check("zero_exp", 32'(out_exp), 32'd0);
        check("zero_sign", 32'(out_sign), 32'd1);
        check_flags("zero", 1'b1, 1'b0, 1'b0);
        release_out("zero");

        // Already normalized passthrough
        run_op(1'b0, 8'd100, 24'hC00000, 1'b0);
        check("pass_lat", 32'(lat), 32'd1);
        check("pass_exp", 32'(out_exp), 32'd100);
        check("pass_frac", 32'(out_frac), 32'h400000);
        check("pass_shift", 32'(out_shift), 32'd0);
        check_flags("pass", 1'b0, 1'b0, 1'b0);
        release_out("pass");

        // Underflow after 4 shifts (exp 5 -> 1, then flush)
        run_op(1'b0, 8'd5, 24'h000100, 1'b0);
        check("unf_lat", 32'(lat), 32'd6);
        check("unf_exp", 32'(out_exp), 32'd0);
        check("unf_frac", 32'(out_frac), 32'h0);
        check("unf_shift", 32'(out_shift), 32'd4);
        check_flags("unf", 1'b1, 1'b0, 1'b1);
        release_out("unf");

        // Zero exponent with unnormalized mantissa flushes on the first SHIFT cycle
        run_op(1'b1, 8'd0, 24'h000001, 1'b0);
        check("unf0_lat", 32'(lat), 32'd2);
        check("unf0_shift", 32'(out_shift), 32'd0);
        check("unf0_sign", 32'(out_sign), 32'd1);
        check_flags("unf0", 1'b1, 1'b0, 1'b1);
        release_out("unf0");

        // Overflow: carry out of exponent 254
        run_op(1'b0, 8'd254, 24'hFFFFFF, 1'b1);
        check("ovf_lat", 32'(lat), 32'd1);
        check("ovf_exp", 32'(out_exp), 32'd255);
        check("ovf_frac", 32'(out_frac), 32'h0);
        check_flags("ovf", 1'b0, 1'b1, 1'b0);
        release_out("ovf");

        // Largest non-overflowing carry: exp 253 -> 254
        run_op(1'b1, 8'd253, 24'hFFFFFF, 1'b1);
        check("c253_exp", 32'(out_exp), 32'd254);
        check("c253_frac", 32'(out_frac), 32'h7FFFFF);
        check_flags("c253", 1'b0, 1'b0, 1'b0);
        release_out("c253");

        // Backpressure: one shift, then hold DONE for 5 cycles while upstream pushes new data
        run_op(1'b1, 8'd130, 24'h400000, 1'b0);
        check("bp_lat", 32'(lat), 32'd2);
        @(negedge clk);
        in_sign = 1'b0; in_exp = 8'd7; in_mant = 24'h800000; in_cout = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_exp", 32'(out_exp), 32'd129);
            check("bp_frac", 32'(out_frac), 32'h0);
            check("bp_shift", 32'(out_shift), 32'd1);
            check("bp_sign", 32'(out_sign), 32'd1);
        end
        // out_ready with in_valid still high: the DONE-cycle input must not be taken
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0; in_valid = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("bp_no_accept", 32'(out_valid), 32'd0);

        // Reset during a 10-shift operation aborts it
        @(negedge clk);
        in_sign = 1'b0; in_exp = 8'd127; in_mant = 24'h002000; in_cout = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_exp", 32'(out_exp), 32'd0);
        check("mid_rst_shift", 32'(out_shift), 32'd0);
        check("mid_rst_sign", 32'(out_sign), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("mid_no_valid", 32'(out_valid), 32'd0);

        // Same 10-shift operation run to completion
        run_op(1'b0, 8'd127, 24'h002000, 1'b0);
        check("ten_lat", 32'(lat), 32'd11);
        check("ten_exp", 32'(out_exp), 32'd117);
        check("ten_frac", 32'(out_frac), 32'h0);
        check("ten_shift", 32'(out_shift), 32'd10);
        check_flags("ten", 1'b0, 1'b0, 1'b0);
        release_out("ten");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
